bus_regfile: RTL and testbench
==============================

# bus_regfile

Parametrised register file with an integrated source-select bus. It holds NREGS general registers of WIDTH bits and drives one registered bus output, sourced from any register or from an external immediate. It adds write-to-read forwarding, a valid strobe and a sticky illegal-select flag. It sits between the controller and the ALU in the lab datapath and is the bus source for every operand transfer.

## Interface
Parameters:
- WIDTH, 16, data width of registers, immediate and bus.
- NREGS, 8, number of general registers (2..64).
- SELW, $clog2(NREGS+1), read-select width (derived, not overridden).
- WSELW, $clog2(NREGS), write-select width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_sel  in  WSELW  destination register index.
- wr_data  in  WIDTH  write data.
- rd_req  in  1  capture the selected source onto the bus this edge.
- rd_sel  in  SELW  source code: 0..NREGS-1 selects a register; NREGS selects the immediate; codes above NREGS are illegal.
- im_d  in  WIDTH  immediate data.
- err_clr  in  1  clears sel_err.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  one-cycle strobe: bus_out updated last edge.
- sel_err  out  1  sticky illegal-select or illegal-write flag.

## Operation
- Reset (rst_n=0 at a rising edge): all registers, bus_out, bus_valid and sel_err go to 0. Reset overrides every other input that cycle, including an in-flight wr_en or rd_req.
- Write: when wr_en=1 and wr_sel<NREGS, reg[wr_sel] <= wr_data.
  - wr_sel>=NREGS (only possible when NREGS is not a power of 2): the write is dropped and sel_err <= 1.
- Read: when rd_req=1, bus_out <= source(rd_sel) and bus_valid <= 1. When rd_req=0, bus_out holds its value and bus_valid <= 0.
- Forwarding: if rd_req, wr_en and rd_sel==wr_sel (register code) are all asserted in the same cycle, bus_out takes wr_data, never the stale register value.
- Illegal read code (rd_sel>NREGS) with rd_req=1:
  - bus_out <= 0;
  - bus_valid <= 1;
  - sel_err <= 1.
- Errors are only raised on a strobed operation. rd_sel and wr_sel are don't-care while their strobe is low.
- sel_err is cleared by err_clr=1. If a new error and err_clr occur in the same cycle, the error wins and sel_err stays 1.

## Timing
- Write latency: 1 edge. The value is readable through the register path on the next cycle, and through forwarding in the same cycle.
- Read latency: 1 edge, from rd_req to bus_out/bus_valid.
- rd_req may be asserted every cycle (full throughput). Back-to-back reads give back-to-back bus_valid pulses.
- No combinational path from any input to any output.
- All outputs are 0 in the first cycle after reset is released.

## Structure
- Package bus_pkg:
  - defaults BUS_WIDTH=16, BUS_NREGS=8;
  - function imm_code(nregs) returning the immediate select code.
- Sub-module bus_src_mux (combinational):
  - inputs: register array, im_d, wr forwarding info, rd_sel;
  - outputs: selected value and an illegal flag.
- bus_regfile holds the register array, the bus_out/bus_valid pipeline register and the sel_err flop.

## Test plan
- Reset, then rd_req with rd_sel=0..7 and 8 (im_d=16'hBEEF) -> bus_out=0 for all registers, 16'hBEEF for the immediate, bus_valid pulses each cycle.
- Write reg3=16'h1234, then read rd_sel=3 the next cycle -> bus_out=16'h1234 one edge after rd_req.
- Same-cycle wr_en(wr_sel=5, wr_data=16'hA5A5) and rd_req(rd_sel=5) -> bus_out=16'hA5A5.
- rd_sel=4'hF with rd_req -> bus_out=0, bus_valid=1, sel_err=1 held. err_clr together with another illegal read -> sel_err stays 1. err_clr alone -> 0.
- Assert rst_n=0 in the same cycle as wr_en to reg2 -> reg2 reads 0 afterwards, and bus_valid=0 and sel_err=0 after reset.
- NREGS=5, WIDTH=8: wr_sel=6 with wr_en -> no register changes and sel_err=1. rd_sel=5 reads im_d; rd_sel=6 is flagged illegal.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared defaults and select-code helpers for the bus register file.
package bus_pkg;
   localparam int BUS_WIDTH = 16;
   localparam int BUS_NREGS = 8;

   // The immediate sits one code above the last register.
   function automatic int imm_code(input int nregs);
      return nregs;
   endfunction
endpackage

// File: rtl/bus_regfile_if.sv
// Write/read/error signal bundle between the controller and bus_regfile.
interface bus_regfile_if
   import bus_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH,
   parameter int NREGS = BUS_NREGS
);
   localparam int SELW  = $clog2(NREGS + 1);
   localparam int WSELW = $clog2(NREGS);

   logic             wr_en;
   logic [WSELW-1:0] wr_sel;
   logic [WIDTH-1:0] wr_data;
   logic             rd_req;
   logic [SELW-1:0]  rd_sel;
   logic [WIDTH-1:0] im_d;
   logic             err_clr;
   logic [WIDTH-1:0] bus_out;
   logic             bus_valid;
   logic             sel_err;

   modport master (
      output wr_en, wr_sel, wr_data, rd_req, rd_sel, im_d, err_clr,
      input  bus_out, bus_valid, sel_err
   );

   modport slave (
      input  wr_en, wr_sel, wr_data, rd_req, rd_sel, im_d, err_clr,
      output bus_out, bus_valid, sel_err
   );
endinterface

// File: rtl/bus_src_mux.sv
// Combinational bus source select: register, forwarded write data or immediate.
module bus_src_mux
   import bus_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH,
   parameter int NREGS = BUS_NREGS,
   localparam int SELW  = $clog2(NREGS + 1),
   localparam int WSELW = $clog2(NREGS)
) (
   input  logic [NREGS-1:0][WIDTH-1:0] regs,
   input  logic [WIDTH-1:0]            im_d,
   input  logic                        fwd_en,
   input  logic [WSELW-1:0]            wr_sel,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic [SELW-1:0]             rd_sel,
   output logic [WIDTH-1:0]            data,
   output logic                        illegal
);
   localparam logic [SELW-1:0] IMM = SELW'(imm_code(NREGS));

   logic [WSELW-1:0] rd_idx;

   assign rd_idx = rd_sel[WSELW-1:0];

   always_comb begin
      data    = '0;
      illegal = 1'b0;
      if (rd_sel < IMM) begin
         // A same-cycle write to the selected register must win over the stale copy.
         if (fwd_en && (rd_idx == wr_sel)) data = wr_data;
         else                              data = regs[rd_idx];
      end else if (rd_sel == IMM) begin
         data = im_d;
      end else begin
         illegal = 1'b1;
      end
   end
endmodule

// File: rtl/bus_regfile.sv
// General register file with a registered source-select bus and sticky select error.
module bus_regfile
   import bus_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH,
   parameter int NREGS = BUS_NREGS,
   localparam int WSELW = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   bus_regfile_if.slave  bus
);
   localparam logic [WSELW:0] NREGS_W = (WSELW + 1)'(NREGS);

   logic [NREGS-1:0][WIDTH-1:0] regs;
   logic [WIDTH-1:0]            bus_q;
   logic                        valid_q;
   logic                        err_q;
   logic [WIDTH-1:0]            mux_data;
   logic                        rd_illegal;
   logic                        wr_legal;
   logic                        new_err;

   assign wr_legal = ({1'b0, bus.wr_sel} < NREGS_W);
   assign new_err  = (bus.wr_en && !wr_legal) || (bus.rd_req && rd_illegal);

   bus_src_mux #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_mux (
      .regs    (regs),
      .im_d    (bus.im_d),
      .fwd_en  (bus.wr_en && wr_legal),
      .wr_sel  (bus.wr_sel),
      .wr_data (bus.wr_data),
      .rd_sel  (bus.rd_sel),
      .data    (mux_data),
      .illegal (rd_illegal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regs    <= '0;
         bus_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (bus.wr_en && wr_legal) regs[bus.wr_sel] <= bus.wr_data;
         if (bus.rd_req) bus_q <= mux_data;
         valid_q <= bus.rd_req;
         // A fresh error outranks a simultaneous clear.
         if (new_err)          err_q <= 1'b1;
         else if (bus.err_clr) err_q <= 1'b0;
      end
   end

   assign bus.bus_out   = bus_q;
   assign bus.bus_valid = valid_q;
   assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_bus_regfile.sv
// Bench for bus_regfile: directed vector table, NREGS=5 corner sequence, randomized model check.
module tb_bus_regfile;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   bus_regfile_if #(.WIDTH(16), .NREGS(8)) if8 ();
   bus_regfile_if #(.WIDTH(8),  .NREGS(5)) if5 ();

   bus_regfile #(.WIDTH(16), .NREGS(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   bus_regfile #(.WIDTH(8),  .NREGS(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(if5));

   typedef struct {
      logic        rst;
      logic        we;
      int          ws;
      logic [15:0] wd;
      logic        rr;
      int          rs;
      logic [15:0] im;
      logic        ec;
      logic [15:0] eb;
      logic        ev;
      logic        ee;
   } vec_t;

   vec_t tbl[20];

   logic [15:0] m_regs[2][64];
   logic [15:0] m_bus[2];
   logic        m_valid[2];
   logic        m_err[2];

   function automatic vec_t mk(logic rst, logic we, int ws, logic [15:0] wd, logic rr, int rs,
                               logic [15:0] im, logic ec, logic [15:0] eb, logic ev, logic ee);
      vec_t v;
      v.rst = rst; v.we = we; v.ws = ws; v.wd = wd; v.rr = rr; v.rs = rs;
      v.im = im; v.ec = ec; v.eb = eb; v.ev = ev; v.ee = ee;
      return v;
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive8(logic we, int ws, logic [15:0] wd, logic rr, int rs, logic [15:0] im, logic ec);
      if8.wr_en = we; if8.wr_sel = ws[2:0]; if8.wr_data = wd;
      if8.rd_req = rr; if8.rd_sel = rs[3:0]; if8.im_d = im; if8.err_clr = ec;
   endtask

   task automatic drive5(logic we, int ws, logic [7:0] wd, logic rr, int rs, logic [7:0] im, logic ec);
      if5.wr_en = we; if5.wr_sel = ws[2:0]; if5.wr_data = wd;
      if5.rd_req = rr; if5.rd_sel = rs[2:0]; if5.im_d = im; if5.err_clr = ec;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check5(string nm, logic [7:0] eb, logic ev, logic ee);
      check({nm, " bus5"},   {24'd0, if5.bus_out}, {24'd0, eb});
      check({nm, " valid5"}, {31'd0, if5.bus_valid}, {31'd0, ev});
      check({nm, " err5"},   {31'd0, if5.sel_err}, {31'd0, ee});
   endtask

   // Behavioural reference: read sees pre-write contents except for a matching same-cycle write.
   task automatic model_step(int d, int nregs, logic rst, logic we, int ws, logic [15:0] wd,
                             logic rr, int rs, logic [15:0] im, logic ec);
      logic ne;
      ne = 1'b0;
      if (!rst) begin
         for (int i = 0; i < 64; i++) m_regs[d][i] = '0;
         m_bus[d] = '0; m_valid[d] = 1'b0; m_err[d] = 1'b0;
         return;
      end
      if (rr) begin
         if (rs < nregs)       m_bus[d] = (we && ws == rs) ? wd : m_regs[d][rs];
         else if (rs == nregs) m_bus[d] = im;
         else begin
            m_bus[d] = '0;
            ne = 1'b1;
         end
      end
      m_valid[d] = rr;
      if (we) begin
         if (ws < nregs) m_regs[d][ws] = wd;
         else            ne = 1'b1;
      end
      if (ne)      m_err[d] = 1'b1;
      else if (ec) m_err[d] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      drive8(0, 0, 0, 0, 0, 0, 0);
      drive5(0, 0, 0, 0, 0, 0, 0);

      //             rst we ws wd       rr rs  im        ec eb        ev ee
      tbl[0]  = mk(0, 0, 0, 16'h0,    0, 0,  16'h0,    0, 16'h0,    0, 0);
      for (int i = 0; i < 8; i++)
         tbl[1+i] = mk(1, 0, 0, 16'h0, 1, i, 16'hBEEF, 0, 16'h0, 1, 0);
      tbl[9]  = mk(1, 0, 0, 16'h0,    1, 8,  16'hBEEF, 0, 16'hBEEF, 1, 0);
      tbl[10] = mk(1, 1, 3, 16'h1234, 0, 0,  16'h0,    0, 16'hBEEF, 0, 0);
      tbl[11] = mk(1, 0, 0, 16'h0,    1, 3,  16'h0,    0, 16'h1234, 1, 0);
      tbl[12] = mk(1, 1, 5, 16'hA5A5, 1, 5,  16'h0,    0, 16'hA5A5, 1, 0);
      tbl[13] = mk(1, 0, 0, 16'h0,    1, 15, 16'h0,    0, 16'h0,    1, 1);
      tbl[14] = mk(1, 0, 0, 16'h0,    0, 0,  16'h0,    0, 16'h0,    0, 1);
      tbl[15] = mk(1, 0, 0, 16'h0,    1, 15, 16'h0,    1, 16'h0,    1, 1);
      tbl[16] = mk(1, 0, 0, 16'h0,    0, 0,  16'h0,    1, 16'h0,    0, 0);
      tbl[17] = mk(0, 1, 2, 16'h7777, 1, 5,  16'h0,    0, 16'h0,    0, 0);
      tbl[18] = mk(1, 0, 0, 16'h0,    1, 2,  16'h0,    0, 16'h0,    1, 0);
      tbl[19] = mk(1, 0, 0, 16'h0,    1, 5,  16'h0,    0, 16'h0,    1, 0);

      for (int i = 0; i < 20; i++) begin
         rst_n = tbl[i].rst;
         drive8(tbl[i].we, tbl[i].ws, tbl[i].wd, tbl[i].rr, tbl[i].rs, tbl[i].im, tbl[i].ec);
         tick();
         check($sformatf("vec%0d bus", i),   {16'd0, if8.bus_out},   {16'd0, tbl[i].eb});
         check($sformatf("vec%0d valid", i), {31'd0, if8.bus_valid}, {31'd0, tbl[i].ev});
         check($sformatf("vec%0d err", i),   {31'd0, if8.sel_err},   {31'd0, tbl[i].ee});
      end
      drive8(0, 0, 0, 0, 0, 0, 0);

      // NREGS=5 corner sequence: out-of-range write, immediate code, illegal codes.
      rst_n = 1'b0;
      drive5(1, 1, 8'h99, 1, 1, 8'h0, 0);
      tick();
      check5("n5 reset", 8'h00, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive5(1, i, 8'(8'h10 + i), 0, 0, 0, 0);
         tick();
      end
      drive5(1, 6, 8'hFF, 0, 0, 0, 0);
      tick();
      check5("n5 wr6", 8'h00, 0, 1);
      for (int i = 0; i < 5; i++) begin
         drive5(0, 0, 0, 1, i, 0, 0);
         tick();
         check5($sformatf("n5 rd%0d", i), 8'(8'h10 + i), 1, 1);
      end
      drive5(0, 0, 0, 0, 0, 0, 1);
      tick();
      check5("n5 clr", 8'h14, 0, 0);
      drive5(0, 0, 0, 1, 5, 8'h3C, 0);
      tick();
      check5("n5 imm", 8'h3C, 1, 0);
      drive5(0, 0, 0, 1, 6, 8'h3C, 0);
      tick();
      check5("n5 rd6", 8'h00, 1, 1);
      drive5(0, 0, 0, 0, 0, 0, 1);
      tick();
      check5("n5 clr2", 8'h00, 0, 0);
      drive5(1, 7, 8'h55, 0, 0, 0, 1);
      tick();
      check5("n5 wr7 clr", 8'h00, 0, 1);

      // Randomized phase against the reference model, starting from reset.
      rst_n = 1'b0;
      drive8(0, 0, 0, 0, 0, 0, 0);
      drive5(0, 0, 0, 0, 0, 0, 0);
      tick();
      model_step(0, 8, 0, 0, 0, 0, 0, 0, 0, 0);
      model_step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 500; c++) begin
         logic        rst, we0, rr0, ec0, we1, rr1, ec1;
         int          ws0, rs0, ws1, rs1;
         logic [15:0] wd0, im0, wd1, im1;
         rst = ($urandom_range(0, 49) != 0);
         we0 = 1'($urandom_range(0, 1)); ws0 = $urandom_range(0, 7);  wd0 = 16'($urandom);
         rr0 = ($urandom_range(0, 3) != 0); rs0 = $urandom_range(0, 15); im0 = 16'($urandom);
         ec0 = ($urandom_range(0, 7) == 0);
         we1 = 1'($urandom_range(0, 1)); ws1 = $urandom_range(0, 7);  wd1 = {8'd0, 8'($urandom)};
         rr1 = ($urandom_range(0, 3) != 0); rs1 = $urandom_range(0, 7); im1 = {8'd0, 8'($urandom)};
         ec1 = ($urandom_range(0, 7) == 0);
         rst_n = rst;
         drive8(we0, ws0, wd0, rr0, rs0, im0, ec0);
         drive5(we1, ws1, wd1[7:0], rr1, rs1, im1[7:0], ec1);
         tick();
         model_step(0, 8, rst, we0, ws0, wd0, rr0, rs0, im0, ec0);
         model_step(1, 5, rst, we1, ws1, wd1, rr1, rs1, im1, ec1);
         check($sformatf("rnd%0d bus8", c),   {16'd0, if8.bus_out},   {16'd0, m_bus[0]});
         check($sformatf("rnd%0d valid8", c), {31'd0, if8.bus_valid}, {31'd0, m_valid[0]});
         check($sformatf("rnd%0d err8", c),   {31'd0, if8.sel_err},   {31'd0, m_err[0]});
         check($sformatf("rnd%0d bus5", c),   {24'd0, if5.bus_out},   {16'd0, m_bus[1]});
         check($sformatf("rnd%0d valid5", c), {31'd0, if5.bus_valid}, {31'd0, m_valid[1]});
         check($sformatf("rnd%0d err5", c),   {31'd0, if5.sel_err},   {31'd0, m_err[1]});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
